sclk_shift_master: RTL
======================

Name: sclk_shift_master

Overview:
- Serial shift engine directly downstream of the programmable clock divider; consumes its divided clock output as a same-domain level (sclk_i) and turns its edges into SPI mode-0 bit timing.
- Accepts a parallel word over a valid/ready handshake, shifts it out on mosi_o while sampling miso_i, then returns the received word with a done pulse.
- Sits between the Avalon-MM register front end (data/start) and the pins.

Parameters:
- DATA_W, 8, frame width in bits (2..32).

Ports:
- clk_i  in  1  system clock; the divider runs on the same clock.
- reset  in  1  synchronous, active-high reset.
- sclk_i  in  1  divided clock level from the clock divider; registered in the clk_i domain, no synchroniser.
- valid_i  in  1  start request; a frame is accepted when valid_i && ready_o.
- data_i  in  DATA_W  transmit word, captured at accept.
- ready_o  out  1  high only in IDLE.
- busy_o  out  1  high in ALIGN, SHIFT and DONE.
- done_o  out  1  one-cycle pulse at frame end.
- data_o  out  DATA_W  last received word; updated in the DONE cycle, held otherwise.
- cs_n_o  out  1  chip select, active low.
- sclk_o  out  1  gated serial clock to the pin.
- mosi_o  out  1  serial data out.
- miso_i  in  1  serial data in.

Behaviour:
- Reset values: ready_o=1, busy_o=0, done_o=0, data_o=0, cs_n_o=1, sclk_o=0, mosi_o=0; state=IDLE, bit counter=0.
- Edge detect: sclk_q <= sclk_i every cycle.
  - rise = sclk_i & ~sclk_q
  - fall = ~sclk_i & sclk_q
- IDLE:
  - On accept: tx_sr<=data_i; cnt<=DATA_W; cs_n_o<=0; mosi_o<=data_i[DATA_W-1]; go to ALIGN.
  - valid_i without ready_o is ignored; there is no queueing.
- ALIGN:
  - Wait for the first fall; ignore any rise seen here. This guarantees a full half-period of mosi setup before the first sclk_o rise.
  - On fall, go to SHIFT with sclk_o=0.
- SHIFT:
  - On rise: sclk_o<=1; rx_sr<={rx_sr[DATA_W-2:0], miso_i}.
  - On fall: sclk_o<=0; cnt<=cnt-1.
    - If cnt==1, go to DONE; mosi_o holds its value.
    - Otherwise shift tx_sr left and drive mosi_o with the next bit.
- DONE (exactly one cycle): done_o=1; data_o<=rx_sr; cs_n_o<=1; mosi_o<=0; go to IDLE. ready_o rises the following cycle.
- Frame invariants: exactly DATA_W sclk_o rising edges per frame; sclk_o is 0 whenever cs_n_o=1.
- Minimum divider setting (divider compare value 0, sclk_i toggles every clk_i): rise and fall alternate on consecutive cycles; the frame must still complete correctly. Worst-case frame length is 2*DATA_W+2 sclk_i edges plus 2 cycles.
- sclk_i static (divider held in reset): the block stays in ALIGN/SHIFT indefinitely with cs_n_o low. There is no timeout; abort is by reset only.
- Reset asserted mid-frame: all outputs return to reset values at the next clk_i edge; a partial rx word is discarded; data_o is cleared.
- Both edges in one cycle is impossible, since sclk_i is a single bit.

Optional Feature:
- Macro: SCLK_SHIFT_LSB_FIRST_EN.
- Defined: bit order is LSB first.
  - Transmit: mosi_o starts at data_i[0]; tx_sr shifts right.
  - Receive: rx_sr shifts right, filling from the MSB, so the first received bit ends in data_o[0].
- Undefined (default): MSB first, as described under Behaviour.

Decomposition:
- Shared package sclk_shift_pkg holds:
  - state encoding constants: IDLE=2'd0, ALIGN=2'd1, SHIFT=2'd2, DONE=2'd3
  - default DATA_W constant
- One natural sub-module: sclk_edge_detect (sclk_q register; rise/fall outputs; synchronous active-high reset clears sclk_q to 0).

Test Plan:
- DATA_W=8, divider compare value 3, data_i=8'hA5, miso_i looped to mosi_o -> 8 sclk_o rises, mosi sequence 1,0,1,0,0,1,0,1, done_o pulse, data_o=8'hA5, cs_n_o high one cycle after done_o.
- Divider compare value 0, data_i=8'h3C, miso_i tied 1 -> frame completes, data_o=8'hFF, exactly 8 sclk_o rises, no rise before the first sclk_i fall.
- valid_i held high with data_i changing to 8'h11 while busy_o=1 -> ignored; first frame's mosi unaffected; second frame starts only once ready_o=1.
- Reset pulsed after the 4th sclk_o rise -> next cycle cs_n_o=1, sclk_o=0, data_o=0, ready_o=1; a new frame 8'h5A then completes normally.
- sclk_i held at 0 after accept -> block stays in ALIGN, cs_n_o=0, no sclk_o activity for 1000 cycles; releasing the divider completes the frame.
- With SCLK_SHIFT_LSB_FIRST_EN defined, data_i=8'h01, loopback -> mosi sequence 1,0,0,0,0,0,0,0; data_o=8'h01.

Source files
------------

// File: rtl/sclk_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sclk_shift_pkg
// Description : Shared state encoding and default frame width for the
//               sclk_shift_master serial shift engine.
// Revision    : 1.0  initial release
// ============================================================================
package sclk_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int c_default_data_w = 8;

endpackage
`default_nettype wire

// File: rtl/sclk_shift_master_if.sv
`default_nettype none
// ============================================================================
// Module      : sclk_shift_master_if
// Description : Word-level handshake between the register front end (master)
//               and the serial shift engine (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface sclk_shift_master_if
  import sclk_shift_pkg::*;
#(
  parameter int DATA_W = c_default_data_w
) ();

  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] data_o;

  modport master (
    output valid_i, data_i,
    input  ready_o, busy_o, done_o, data_o
  );

  modport slave (
    input  valid_i, data_i,
    output ready_o, busy_o, done_o, data_o
  );

endinterface
`default_nettype wire

// File: rtl/sclk_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sclk_edge_detect
// Description : Registers the divided clock level and flags its rising and
//               falling edges in the clk_i domain.
// Revision    : 1.0  initial release
// ============================================================================
module sclk_edge_detect (
  input  logic clk_i,
  input  logic reset,
  input  logic sclk_i,
  output logic rise_o,
  output logic fall_o
);

  logic r_sclk_q;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_sclk_q <= 1'b0;
    end else begin
      r_sclk_q <= sclk_i;
    end
  end

  assign rise_o = sclk_i & ~r_sclk_q;
  assign fall_o = ~sclk_i & r_sclk_q;

endmodule
`default_nettype wire

// File: rtl/sclk_shift_master.sv
`default_nettype none
// ============================================================================
// Module      : sclk_shift_master
// Description : SPI mode-0 shift engine driven by the divided clock level.
//               Define SCLK_SHIFT_LSB_FIRST_EN for LSB-first bit order.
// Revision    : 1.0  initial release
// ============================================================================
module sclk_shift_master
  import sclk_shift_pkg::*;
#(
  parameter int DATA_W = c_default_data_w
) (
  input  logic                clk_i,
  input  logic                reset,
  sclk_shift_master_if.slave  bus,
  input  logic                sclk_i,
  output logic                cs_n_o,
  output logic                sclk_o,
  output logic                mosi_o,
  input  logic                miso_i
);

  localparam int c_cnt_w = $clog2(DATA_W + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt,  w_cnt_nxt;
  logic [DATA_W-1:0]   r_tx_sr, w_tx_nxt;
  logic [DATA_W-1:0]   r_rx_sr, w_rx_nxt;
  logic [DATA_W-1:0]   r_data,  w_data_nxt;
  logic                r_cs_n,  w_cs_n_nxt;
  logic                r_sclk,  w_sclk_nxt;
  logic                w_rise;
  logic                w_fall;
  logic [DATA_W-1:0]   w_tx_shift;
  logic [DATA_W-1:0]   w_rx_shift;
  logic                w_tx_bit;

  sclk_edge_detect u_edge (
    .clk_i  (clk_i),
    .reset  (reset),
    .sclk_i (sclk_i),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

`ifdef SCLK_SHIFT_LSB_FIRST_EN
  assign w_tx_shift = {1'b0, r_tx_sr[DATA_W-1:1]};
  assign w_rx_shift = {miso_i, r_rx_sr[DATA_W-1:1]};
  assign w_tx_bit   = r_tx_sr[0];
`else
  assign w_tx_shift = {r_tx_sr[DATA_W-2:0], 1'b0};
  assign w_rx_shift = {r_rx_sr[DATA_W-2:0], miso_i};
  assign w_tx_bit   = r_tx_sr[DATA_W-1];
`endif

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tx_nxt    = r_tx_sr;
    w_rx_nxt    = r_rx_sr;
    w_data_nxt  = r_data;
    w_cs_n_nxt  = r_cs_n;
    w_sclk_nxt  = r_sclk;
    case (r_state)
      IDLE: begin
        if (bus.valid_i) begin
          w_tx_nxt    = bus.data_i;
          w_cnt_nxt   = c_cnt_w'(DATA_W);
          w_cs_n_nxt  = 1'b0;
          w_state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        // A rise here is ignored so mosi gets a full half-period of setup.
        if (w_fall) begin
          w_sclk_nxt  = 1'b0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_rise) begin
          w_sclk_nxt = 1'b1;
          w_rx_nxt   = w_rx_shift;
        end else if (w_fall) begin
          w_sclk_nxt = 1'b0;
          w_cnt_nxt  = r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            w_state_nxt = DONE;
          end else begin
            w_tx_nxt = w_tx_shift;
          end
        end
      end
      DONE: begin
        w_data_nxt  = r_rx_sr;
        w_cs_n_nxt  = 1'b1;
        w_tx_nxt    = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_cnt   <= '0;
      r_tx_sr <= '0;
      r_rx_sr <= '0;
      r_data  <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_tx_sr <= w_tx_nxt;
      r_rx_sr <= w_rx_nxt;
      r_data  <= w_data_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sclk  <= w_sclk_nxt;
    end
  end

  // mosi is the live end of the transmit register, cleared in DONE and reset.
  assign mosi_o      = w_tx_bit;
  assign cs_n_o      = r_cs_n;
  assign sclk_o      = r_sclk;
  assign bus.ready_o = (r_state == IDLE);
  assign bus.busy_o  = (r_state != IDLE);
  assign bus.done_o  = (r_state == DONE);
  assign bus.data_o  = r_data;

endmodule
`default_nettype wire
